// File: rtl/capture_pkg.sv
// Shared constants and state encoding for the capture sequencer.
package capture_pkg;

  localparam int unsigned N_COEF = 16;
  localparam int unsigned AW     = $clog2(N_COEF);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StFill    = 3'd2,
    StCapture = 3'd3,
    StFull    = 3'd4,
    StRd      = 3'd5,
    StTx      = 3'd6,
    StTxWait  = 3'd7
  } state_e;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector for a debounced button level.
module edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/capture_sequencer.sv
// Sequences coefficient load, FIR capture into a FIFO and UART drain of the FIFO.
module capture_sequencer #(
  parameter int unsigned N_COEF = capture_pkg::N_COEF,
  parameter int unsigned AW     = capture_pkg::AW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          carga_coef_i,
  input  logic          send_i,
  input  logic          coef_valid_i,
  input  logic          full_fir_reg_i,
  input  logic          full_fifo_i,
  input  logic          empty_i,
  input  logic          tx_busy_i,
  output logic          en_recepcion_o,
  output logic          coef_we_o,
  output logic [AW-1:0] coef_addr_o,
  output logic          en_fir_o,
  output logic          wr_o,
  output logic          rd_o,
  output logic          tx_start_o,
  output logic          led_full_o,
  output logic [2:0]    state_o
);

  import capture_pkg::*;

  localparam logic [AW:0] LastCoef = (AW+1)'(N_COEF - 1);
  localparam logic [AW:0] CntOne   = (AW+1)'(1);

  logic        carga_edge;
  logic        send_edge;
  state_e      state_q, state_d;
  logic [AW:0] coef_cnt_q, coef_cnt_d;
  logic        txwait_first_q, txwait_first_d;

  edge_detect u_carga_edge (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .level_i (carga_coef_i),
    .rise_o  (carga_edge)
  );

  edge_detect u_send_edge (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .level_i (send_i),
    .rise_o  (send_edge)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      coef_cnt_q     <= '0;
      txwait_first_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      coef_cnt_q     <= coef_cnt_d;
      txwait_first_q <= txwait_first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    coef_cnt_d = coef_cnt_q;
    if (carga_edge) begin
      // A reload request overrides whatever the sequencer was doing.
      state_d    = StLoad;
      coef_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StLoad: begin
          if (coef_valid_i) begin
            coef_cnt_d = coef_cnt_q + CntOne;
            if (coef_cnt_q == LastCoef) state_d = StFill;
          end
        end
        StFill:    if (full_fir_reg_i) state_d = StCapture;
        StCapture: if (full_fifo_i) state_d = StFull;
        StFull:    if (send_edge) state_d = StRd;
        StRd:      state_d = StTx;
        StTx:      if (!tx_busy_i) state_d = StTxWait;
        StTxWait: begin
          // The transmitter raises busy a cycle after the start pulse.
          if (!txwait_first_q && !tx_busy_i) state_d = empty_i ? StFill : StRd;
        end
        default:   state_d = StIdle;
      endcase
    end
    txwait_first_d = (state_q != StTxWait) && (state_d == StTxWait);
  end

  always_comb begin
    en_recepcion_o = 1'b0;
    coef_we_o      = 1'b0;
    coef_addr_o    = '0;
    en_fir_o       = 1'b0;
    wr_o           = 1'b0;
    rd_o           = 1'b0;
    tx_start_o     = 1'b0;
    led_full_o     = 1'b0;
    state_o        = 3'd0;
    if (!rst_i) begin
      state_o = state_q;
      unique case (state_q)
        StLoad: begin
          en_recepcion_o = 1'b1;
          coef_we_o      = coef_valid_i;
          coef_addr_o    = coef_cnt_q[AW-1:0];
        end
        StFill: en_fir_o = 1'b1;
        StCapture: begin
          en_fir_o = 1'b1;
          wr_o     = !full_fifo_i;
        end
        StFull:  led_full_o = 1'b1;
        StRd:    rd_o = 1'b1;
        StTx:    tx_start_o = !tx_busy_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized self-checking bench for capture_sequencer with FIFO and UART models.
module tb_capture_sequencer;
  import capture_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, carga, send, coef_valid, full_fir, tx_busy;
  logic          full_fifo, empty;
  logic          en_recepcion, coef_we, en_fir, wr, rd, tx_start, led_full;
  logic [AW-1:0] coef_addr;
  logic [2:0]    state;
  logic [13:0]   outs;

  int total, bad;
  int n_wr, n_rd, n_tx, n_we;
  int exp_addr;
  int fifo_cnt, fifo_depth;
  bit mon_en;

  assign full_fifo = (fifo_cnt >= fifo_depth);
  assign empty     = (fifo_cnt == 0);
  assign outs = {en_recepcion, coef_we, coef_addr, en_fir, wr, rd, tx_start, led_full, state};

  capture_sequencer #(.N_COEF(N_COEF), .AW(AW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .carga_coef_i   (carga),
    .send_i         (send),
    .coef_valid_i   (coef_valid),
    .full_fir_reg_i (full_fir),
    .full_fifo_i    (full_fifo),
    .empty_i        (empty),
    .tx_busy_i      (tx_busy),
    .en_recepcion_o (en_recepcion),
    .coef_we_o      (coef_we),
    .coef_addr_o    (coef_addr),
    .en_fir_o       (en_fir),
    .wr_o           (wr),
    .rd_o           (rd),
    .tx_start_o     (tx_start),
    .led_full_o     (led_full),
    .state_o        (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Invariants and event counters, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("rd_and_wr", 32'(rd & wr), 0);
        chk("start_while_busy", 32'(tx_start & tx_busy), 0);
        chk("rd_when_empty", 32'(rd & empty), 0);
        if (coef_we) begin
          chk("coef_addr", 32'(coef_addr), 32'(exp_addr % N_COEF));
          exp_addr++;
          n_we++;
        end
        n_wr += int'(wr);
        n_rd += int'(rd);
        n_tx += int'(tx_start);
      end
    end
  end

  // FIFO occupancy model.
  initial begin : fifo_model
    bit w, r;
    forever begin
      @(negedge clk);
      w = wr;
      r = rd;
      @(posedge clk);
      #1;
      if (w && fifo_cnt < fifo_depth) fifo_cnt++;
      if (r && fifo_cnt > 0) fifo_cnt--;
    end
  end

  // UART transmitter: busy for a random number of cycles after each start.
  initial begin : uart_model
    int n;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && !rst_i) begin
        n = $urandom_range(2, 6);
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (n) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic wait_state(input state_e s, input int lim, input string tag);
    for (int i = 0; i < lim && state != s; i++) tick();
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic do_load(input int n);
    int hold, w0;
    carga = 1'b0;
    tick();
    w0 = n_we;
    carga = 1'b1;
    exp_addr = 0;
    tick();
    chk("load_state", 32'(state), 32'(StLoad));
    chk("load_rx_en", 32'(en_recepcion), 1);
    hold = $urandom_range(0, 3);
    for (int k = 0; k < n; k++) begin
      carga = (k < hold);
      coef_valid = 1'b1;
      tick();
      coef_valid = 1'b0;
      if (k < n - 1) repeat ($urandom_range(0, 2)) tick();
    end
    carga = 1'b0;
    chk("load_we_count", 32'(n_we - w0), 32'(n));
    if (n == N_COEF) begin
      chk("load_to_fill", 32'(state), 32'(StFill));
      chk("fill_fir_en", 32'(en_fir), 1);
    end else begin
      chk("load_stay", 32'(state), 32'(StLoad));
    end
  endtask

  task automatic do_capture(input int depth);
    int w0;
    fifo_depth = depth;
    fifo_cnt = 0;
    repeat ($urandom_range(1, 3)) tick();
    chk("fill_hold", 32'(state), 32'(StFill));
    chk("fill_no_wr", 32'(wr), 0);
    w0 = n_wr;
    full_fir = 1'b1;
    wait_state(StFull, 100, "cap_to_full");
    full_fir = 1'b0;
    chk("cap_wr_count", 32'(n_wr - w0), 32'(depth));
    chk("full_led", 32'(led_full), 1);
    chk("full_fir_off", 32'(en_fir), 0);
    repeat (2) tick();
    chk("full_hold", 32'(state), 32'(StFull));
  endtask

  task automatic do_transfer(input int depth, input int hold);
    int r0, t0;
    r0 = n_rd;
    t0 = n_tx;
    for (int i = 0; i < 1000; i++) begin
      send = (i < hold);
      tick();
      if (i >= hold && state == StFill) break;
    end
    send = 1'b0;
    chk("xfer_end_fill", 32'(state), 32'(StFill));
    chk("xfer_rd_count", 32'(n_rd - r0), 32'(depth));
    chk("xfer_tx_count", 32'(n_tx - t0), 32'(depth));
    chk("xfer_fifo_drained", 32'(fifo_cnt), 0);
  endtask

  initial begin
    int w0, r0, t0, d;
    total = 0; bad = 0;
    n_wr = 0; n_rd = 0; n_tx = 0; n_we = 0; exp_addr = 0;
    mon_en = 1'b0;
    rst_i = 1'b1; carga = 1'b0; send = 1'b0; coef_valid = 1'b0; full_fir = 1'b0;
    fifo_cnt = 0; fifo_depth = 8;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      coef_valid = 1'($urandom_range(0, 1));
      send = 1'($urandom_range(0, 1));
      #1 chk("reset_outs", 32'(outs), 0);
      tick();
    end
    coef_valid = 1'b0; send = 1'b0; rst_i = 1'b0; mon_en = 1'b1;
    tick();
    chk("idle_state", 32'(state), 32'(StIdle));

    // Noise in IDLE must not leave it.
    w0 = n_we;
    for (int i = 0; i < 8; i++) begin
      coef_valid = 1'($urandom_range(0, 1));
      send = 1'($urandom_range(0, 1));
      full_fir = 1'($urandom_range(0, 1));
      tick();
    end
    coef_valid = 1'b0; send = 1'b0; full_fir = 1'b0;
    tick();
    chk("idle_stay", 32'(state), 32'(StIdle));
    chk("idle_no_we", 32'(n_we - w0), 0);

    // Interrupted load, then a full reload restarting at address 0.
    do_load($urandom_range(1, 10));
    do_load(N_COEF);

    // Strobes and send edges in FILL are ignored.
    w0 = n_we; r0 = n_rd;
    for (int i = 0; i < 4; i++) begin
      coef_valid = 1'b1; send = 1'b1;
      tick();
      coef_valid = 1'b0; send = 1'b0;
      tick();
    end
    chk("fill_ignore_state", 32'(state), 32'(StFill));
    chk("fill_ignore_we", 32'(n_we - w0), 0);
    chk("fill_ignore_rd", 32'(n_rd - r0), 0);

    do_capture(8);
    do_transfer(8, 50);
    d = $urandom_range(1, 6);
    do_capture(d);
    do_transfer(d, $urandom_range(1, 3));
    do_capture(3);
    do_transfer(3, 1);

    // Reload request in TXWAIT with a simultaneous send edge.
    do_capture(4);
    send = 1'b1;
    tick();
    send = 1'b0;
    wait_state(StTxWait, 20, "reach_txwait");
    t0 = n_tx;
    carga = 1'b1; send = 1'b1;
    tick();
    chk("abort_state", 32'(state), 32'(StLoad));
    chk("abort_enables", 32'({en_fir, wr, rd, tx_start}), 0);
    carga = 1'b0; send = 1'b0;
    repeat (10) tick();
    chk("abort_no_tx", 32'(n_tx - t0), 0);
    chk("abort_still_load", 32'(state), 32'(StLoad));
    fifo_cnt = 0;
    do_load(N_COEF);

    // Reset during a transfer abandons it.
    do_capture(5);
    send = 1'b1;
    tick();
    send = 1'b0;
    wait_state(StRd, 5, "reach_rd");
    rst_i = 1'b1;
    #1 chk("rst_outs_now", 32'(outs), 0);
    tick();
    rst_i = 1'b0;
    chk("rst_idle", 32'(state), 32'(StIdle));
    t0 = n_tx;
    repeat (15) tick();
    chk("rst_no_tx", 32'(n_tx - t0), 0);
    fifo_cnt = 0;

    // Reset pulse during CAPTURE, then strobes without a reload request.
    do_load(N_COEF);
    fifo_depth = 12;
    fifo_cnt = 0;
    full_fir = 1'b1;
    wait_state(StCapture, 10, "reach_capture");
    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    full_fir = 1'b0;
    chk("cap_rst_outs", 32'(outs), 0);
    w0 = n_we;
    for (int i = 0; i < 4; i++) begin
      coef_valid = 1'b1;
      tick();
      coef_valid = 1'b0;
      tick();
    end
    chk("post_rst_no_we", 32'(n_we - w0), 0);
    chk("post_rst_idle", 32'(state), 32'(StIdle));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
